// File: rtl/debug_pkg.sv
// Shared definitions for the board debug display path: channel encodings and
// the active-low seven-segment glyph table for hex digits.
package debug_pkg;

  localparam logic [1:0] CH_PC   = 2'd0;
  localparam logic [1:0] CH_ADDR = 2'd1;
  localparam logic [1:0] CH_REG  = 2'd2;
  localparam logic [1:0] CH_INST = 2'd3;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return GLYPH_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg
  import debug_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = hex_glyph(nibble);
  end

endmodule

// File: rtl/debug_seg_display.sv
// Eight-digit multiplexed hex display of one of four CPU debug channels. The
// selected channel is captured once per frame so a frame never mixes values.
module debug_seg_display
  import debug_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [31:0] debug_in0,
  input  logic [31:0] debug_in1,
  input  logic [31:0] debug_in2,
  input  logic [31:0] debug_in3,
  input  logic [1:0]  sel,
  input  logic        hold,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [1:0]       sel_m_q, sel_s_q;
  logic             hold_m_q, hold_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      snap_q, snap_d;
  logic             tick;
  logic             frame_wrap;
  logic [31:0]      chan_val;
  logic [3:0]       nibble;
  logic [6:0]       glyph_n;

  always_comb begin
    chan_val = debug_in0;
    case (sel_s_q)
      CH_PC:   chan_val = debug_in0;
      CH_ADDR: chan_val = debug_in1;
      CH_REG:  chan_val = debug_in2;
      CH_INST: chan_val = debug_in3;
      default: chan_val = debug_in0;
    endcase
  end

  always_comb begin
    tick       = (cnt_q == CNT_MAX);
    frame_wrap = tick && (idx_q == 3'd7);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = tick ? idx_q + 3'd1 : idx_q;
    snap_d     = snap_q;
    // The load shares the edge with index 7->0, so a new value starts at digit 0.
    if (frame_wrap && !hold_s_q) snap_d = chan_val;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sel_m_q  <= '0;
      sel_s_q  <= '0;
      hold_m_q <= 1'b0;
      hold_s_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      snap_q   <= '0;
    end else begin
      sel_m_q  <= sel;
      sel_s_q  <= sel_m_q;
      hold_m_q <= hold;
      hold_s_q <= hold_m_q;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
    end
  end

  assign nibble = snap_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg_n  (glyph_n)
  );

  // Decimal point on digit 0 flags that the display is frozen.
  assign seg_n = {~((idx_q == 3'd0) && hold_s_q), glyph_n};
  assign an_n  = ~(8'h01 << idx_q);

endmodule

// File: tb/tb_debug_seg_display.sv
// Bench for debug_seg_display: a frame-level reference model (edge count,
// snapshot per frame) plus directed glyph checks at SCAN_DIV = 2.
module tb_debug_seg_display;

  localparam int SD    = 2;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic [31:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [1:0]  sel = '0;
  logic        hold = 1'b0;
  logic [7:0]  seg_n, an_n;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic [6:0] glyph_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  debug_seg_display #(.SCAN_DIV(SD)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .debug_in0 (d0),
    .debug_in1 (d1),
    .debug_in2 (d2),
    .debug_in3 (d3),
    .sel       (sel),
    .hold      (hold),
    .seg_n     (seg_n),
    .an_n      (an_n)
  );

  always #5 clk = ~clk;

  // Reference model: edges since release, two-stage sampled switches,
  // and the value shown for the current frame.
  int          m_k = 0;
  logic [31:0] m_snap = '0;
  logic [1:0]  m_sel_m = '0, m_sel_s = '0;
  logic        m_hold_m = 1'b0, m_hold_s = 1'b0;

  function automatic logic [31:0] chan_of(input logic [1:0] s);
    case (s)
      2'd0: return d0;
      2'd1: return d1;
      2'd2: return d2;
      default: return d3;
    endcase
  endfunction

  function automatic int m_idx();
    return (m_k / SD) % 8;
  endfunction

  function automatic logic [7:0] exp_an();
    logic [7:0] one;
    one = 8'h01;
    return ~(one << m_idx());
  endfunction

  function automatic logic [7:0] exp_seg();
    int nib;
    logic dp_n;
    nib  = int'((m_snap >> (4 * m_idx())) & 32'hF);
    dp_n = !(m_idx() == 0 && m_hold_s);
    return {dp_n, glyph_ref[nib]};
  endfunction

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_k <= 0; m_snap <= '0;
      m_sel_m <= '0; m_sel_s <= '0; m_hold_m <= 1'b0; m_hold_s <= 1'b0;
    end else begin
      if (((m_k + 1) % FRAME == 0) && !m_hold_s) m_snap <= chan_of(m_sel_s);
      m_sel_m  <= sel;  m_sel_s  <= m_sel_m;
      m_hold_m <= hold; m_hold_s <= m_hold_m;
      m_k <= m_k + 1;
    end
  end

  task automatic test_reset();
    sel = 2'd0; hold = 1'b0; d0 = 32'hA5A5_1234;
    #1 aresetn = 1'b0;
    #1;
    checks++;
    if (an_n !== 8'hFE || seg_n !== 8'hC0) begin
      errors++;
      $display("FAIL reset_async an_n=%h seg_n=%h want FE C0", an_n, seg_n);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (an_n !== 8'hFE || seg_n !== 8'hC0) begin
        errors++;
        $display("FAIL reset_hold an_n=%h seg_n=%h want FE C0", an_n, seg_n);
      end
    end
    aresetn = 1'b1;
    #1;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (seg_n[6:0] !== 7'h40 || an_n !== exp_an()) begin
        errors++;
        $display("FAIL first_frame cyc=%0d an_n=%h seg_n=%h want an %h glyph 40",
                 i, an_n, seg_n, exp_an());
      end
    end
  endtask

  task automatic test_scan_order();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an() || seg_n !== exp_seg() || $countones(~an_n) != 1) begin
        errors++;
        $display("FAIL scan_order cyc=%0d an_n=%h seg_n=%h want %h %h",
                 i, an_n, seg_n, exp_an(), exp_seg());
      end
    end
  endtask

  task automatic test_value();
    int want_dig [3] = '{0, 3, 7};
    int p = 0;
    logic [7:0] exp_v;
    logic [7:0] one;
    one = 8'h01;
    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h92);
    exp_q.push_back(8'hF9);
    sel = 2'd0; d0 = 32'h1234_5678;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an() || seg_n !== exp_seg()) begin
        errors++;
        $display("FAIL value_model cyc=%0d an_n=%h seg_n=%h want %h %h",
                 i, an_n, seg_n, exp_an(), exp_seg());
      end
      if (p < 3 && m_snap == 32'h1234_5678 && an_n == ~(one << want_dig[p])) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (seg_n !== exp_v) begin
          errors++;
          $display("FAIL value_digit%0d seg_n=%h want %h", want_dig[p], seg_n, exp_v);
        end
        p++;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL value_timeout pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_hold();
    bit seen = 0;
    hold = 1'b1;
    repeat (4) @(negedge clk);
    d0 = 32'hDEAD_BEEF;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an() || seg_n !== exp_seg()) begin
        errors++;
        $display("FAIL hold_model cyc=%0d an_n=%h seg_n=%h want %h %h",
                 i, an_n, seg_n, exp_an(), exp_seg());
      end
      if (an_n == 8'hFE) begin
        checks++;
        if (seg_n !== 8'h00) begin
          errors++;
          $display("FAIL hold_digit0 seg_n=%h want 00", seg_n);
        end
      end
      if (an_n == 8'h7F) begin
        checks++;
        if (seg_n !== 8'hF9) begin
          errors++;
          $display("FAIL hold_digit7 seg_n=%h want F9", seg_n);
        end
      end
    end
    hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an() || seg_n !== exp_seg()) begin
        errors++;
        $display("FAIL release_model cyc=%0d an_n=%h seg_n=%h want %h %h",
                 i, an_n, seg_n, exp_an(), exp_seg());
      end
      if (!seen && m_snap == 32'hDEAD_BEEF && an_n == 8'hFE) begin
        seen = 1;
        checks++;
        if (seg_n !== 8'h8E) begin
          errors++;
          $display("FAIL release_digit0 seg_n=%h want 8E", seg_n);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL release_timeout seen=0 want 1");
    end
  endtask

  task automatic test_mid_frame_sel();
    bit found = 0;
    bit wrapped = 0;
    int seen = 0;
    logic [31:0] old_val;
    old_val = 32'hDEAD_BEEF;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m_idx() == 4) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midsel_wait found=0 want 1");
    end
    d3 = 32'h0000_0013; sel = 2'd3;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an() || seg_n !== exp_seg()) begin
        errors++;
        $display("FAIL midsel_model cyc=%0d an_n=%h seg_n=%h want %h %h",
                 i, an_n, seg_n, exp_an(), exp_seg());
      end
      if (an_n == 8'hFE) wrapped = 1;
      if (!wrapped) begin
        checks++;
        if (seg_n[6:0] !== glyph_ref[int'((old_val >> (4 * m_idx())) & 32'hF)]) begin
          errors++;
          $display("FAIL midsel_old idx=%0d seg_n=%h", m_idx(), seg_n);
        end
      end else if (an_n == 8'hFE || an_n == 8'hFD) begin
        seen++;
        checks++;
        if (seg_n !== ((an_n == 8'hFE) ? 8'hB0 : 8'hF9)) begin
          errors++;
          $display("FAIL midsel_new an_n=%h seg_n=%h want %h",
                   an_n, seg_n, (an_n == 8'hFE) ? 8'hB0 : 8'hF9);
        end
      end
    end
    checks++;
    if (seen < 2) begin
      errors++;
      $display("FAIL midsel_timeout seen=%0d want >=2", seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an() || seg_n !== exp_seg()) begin
        errors++;
        $display("FAIL random cyc=%0d an_n=%h seg_n=%h want %h %h",
                 i, an_n, seg_n, exp_an(), exp_seg());
      end
      if ($urandom_range(0, 9) == 0) begin
        d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
      end
      if ($urandom_range(0, 22) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) hold = ~hold;
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    hold = 1'b0; sel = 2'd1; d1 = 32'h89AB_CDEF;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m_idx() == 5 && m_snap != 0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL areset_wait found=0 want 1");
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (an_n !== 8'hFE || seg_n !== 8'hC0) begin
      errors++;
      $display("FAIL areset_mid an_n=%h seg_n=%h want FE C0", an_n, seg_n);
    end
    #1 aresetn = 1'b1;
    @(negedge clk);
    checks++;
    if (an_n !== 8'hFE || seg_n !== 8'hC0) begin
      errors++;
      $display("FAIL areset_restart an_n=%h seg_n=%h want FE C0", an_n, seg_n);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an() || seg_n !== exp_seg()) begin
        errors++;
        $display("FAIL areset_model cyc=%0d an_n=%h seg_n=%h want %h %h",
                 i, an_n, seg_n, exp_an(), exp_seg());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_value();
    test_hold();
    test_mid_frame_sel();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
